// File: rtl/dct_1d.sv
// 8-point 1-D DCT-II in fixed point (Q14 coefficients), fully pipelined with 3-cycle latency.
// Optional build macro DCT_1D_SATURATE_EN clamps each coefficient to 32 bits instead of wrapping.
module dct_1d (
    input  logic        aclk,
    input  logic        areset,
    input  logic        in_valid,
    input  logic [31:0] I0,
    input  logic [31:0] I1,
    input  logic [31:0] I2,
    input  logic [31:0] I3,
    input  logic [31:0] I4,
    input  logic [31:0] I5,
    input  logic [31:0] I6,
    input  logic [31:0] I7,
    output logic        out_valid,
    output logic [31:0] O0,
    output logic [31:0] O1,
    output logic [31:0] O2,
    output logic [31:0] O3,
    output logic [31:0] O4,
    output logic [31:0] O5,
    output logic [31:0] O6,
    output logic [31:0] O7
);

    logic               v1_r;
    logic               v2_r;
    logic               v3_r;
    logic               vo_r;
    logic signed [31:0] x_r   [8];
    logic signed [32:0] s_r   [4];
    logic signed [32:0] d_r   [4];
    logic signed [63:0] acc_s [8];
    logic signed [63:0] acc_r [8];
    logic        [31:0] o_r   [8];

    // C[k][n] for n = 0..3; the mirrored half follows from C[k][7-n] = (-1)^k * C[k][n].
    function automatic logic signed [15:0] coef(input logic [2:0] k, input logic [1:0] n);
        logic signed [15:0] c;
        case ({k, n})
            5'd0:    c = 16'sd5793;
            5'd1:    c = 16'sd5793;
            5'd2:    c = 16'sd5793;
            5'd3:    c = 16'sd5793;
            5'd4:    c = 16'sd8035;
            5'd5:    c = 16'sd6811;
            5'd6:    c = 16'sd4551;
            5'd7:    c = 16'sd1598;
            5'd8:    c = 16'sd7568;
            5'd9:    c = 16'sd3135;
            5'd10:   c = -16'sd3135;
            5'd11:   c = -16'sd7568;
            5'd12:   c = 16'sd6811;
            5'd13:   c = -16'sd1598;
            5'd14:   c = -16'sd8035;
            5'd15:   c = -16'sd4551;
            5'd16:   c = 16'sd5793;
            5'd17:   c = -16'sd5793;
            5'd18:   c = -16'sd5793;
            5'd19:   c = 16'sd5793;
            5'd20:   c = 16'sd4551;
            5'd21:   c = -16'sd8035;
            5'd22:   c = 16'sd1598;
            5'd23:   c = 16'sd6811;
            5'd24:   c = 16'sd3135;
            5'd25:   c = -16'sd7568;
            5'd26:   c = 16'sd7568;
            5'd27:   c = -16'sd3135;
            5'd28:   c = 16'sd1598;
            5'd29:   c = -16'sd4551;
            5'd30:   c = 16'sd6811;
            5'd31:   c = -16'sd8035;
            default: c = 16'sd0;
        endcase
        return c;
    endfunction

    function automatic logic signed [63:0] mul(input logic signed [32:0] a,
                                               input logic signed [15:0] c);
        logic signed [63:0] a_ext;
        logic signed [63:0] c_ext;
        a_ext = a;
        c_ext = c;
        return a_ext * c_ext;
    endfunction

    function automatic logic [31:0] round_out(input logic signed [63:0] acc);
        logic signed [63:0] r;
        logic        [31:0] y;
        r = (acc + 64'sd8192) >>> 6'd14;
`ifdef DCT_1D_SATURATE_EN
        if (r > 64'sd2147483647) begin
            y = 32'h7FFF_FFFF;
        end else if (r < -64'sd2147483648) begin
            y = 32'h8000_0000;
        end else begin
            y = r[31:0];
        end
`else
        y = r[31:0];
`endif
        return y;
    endfunction

    // Stage 1: capture the sample vector only when it is marked valid.
    always_ff @(posedge aclk) begin
        if (areset) begin
            v1_r <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                x_r[i] <= 32'sd0;
            end
        end else begin
            v1_r <= in_valid;
            if (in_valid) begin
                x_r[0] <= I0;
                x_r[1] <= I1;
                x_r[2] <= I2;
                x_r[3] <= I3;
                x_r[4] <= I4;
                x_r[5] <= I5;
                x_r[6] <= I6;
                x_r[7] <= I7;
            end
        end
    end

    // Stage 2: symmetric butterfly; 33 bits keeps sum/difference exact.
    always_ff @(posedge aclk) begin
        if (areset) begin
            v2_r <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                s_r[i] <= 33'sd0;
                d_r[i] <= 33'sd0;
            end
        end else begin
            v2_r <= v1_r;
            if (v1_r) begin
                for (int i = 0; i < 4; i++) begin
                    s_r[i] <= {x_r[i][31], x_r[i]} + {x_r[7-i][31], x_r[7-i]};
                    d_r[i] <= {x_r[i][31], x_r[i]} - {x_r[7-i][31], x_r[7-i]};
                end
            end
        end
    end

    // Even coefficients use the butterfly sums, odd ones the differences.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            acc_s[k] = 64'sd0;
            for (int n = 0; n < 4; n++) begin
                if (k[0]) begin
                    acc_s[k] = acc_s[k] + mul(d_r[n], coef(k[2:0], n[1:0]));
                end else begin
                    acc_s[k] = acc_s[k] + mul(s_r[n], coef(k[2:0], n[1:0]));
                end
            end
        end
    end

    // Stage 3: full-width multiply-accumulate results.
    always_ff @(posedge aclk) begin
        if (areset) begin
            v3_r <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                acc_r[k] <= 64'sd0;
            end
        end else begin
            v3_r <= v2_r;
            if (v2_r) begin
                for (int k = 0; k < 8; k++) begin
                    acc_r[k] <= acc_s[k];
                end
            end
        end
    end

    // Output stage: round, narrow to 32 bits, and hold between results.
    always_ff @(posedge aclk) begin
        if (areset) begin
            vo_r <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                o_r[k] <= 32'd0;
            end
        end else begin
            vo_r <= v3_r;
            if (v3_r) begin
                for (int k = 0; k < 8; k++) begin
                    o_r[k] <= round_out(acc_r[k]);
                end
            end
        end
    end

    assign out_valid = vo_r;
    assign O0        = o_r[0];
    assign O1        = o_r[1];
    assign O2        = o_r[2];
    assign O3        = o_r[3];
    assign O4        = o_r[4];
    assign O5        = o_r[5];
    assign O6        = o_r[6];
    assign O7        = o_r[7];

endmodule

// File: tb/tb_dct_1d.sv
// Directed bench for dct_1d: scoreboard of expected results keyed by due edge, checked every cycle.
module tb_dct_1d;

    typedef logic [7:0][31:0] vec_t;
    typedef struct {
        int   due;
        vec_t o;
    } exp_t;

    logic        aclk = 1'b0;
    logic        areset;
    logic        in_valid;
    vec_t        xin;
    logic        out_valid;
    logic [31:0] O0, O1, O2, O3, O4, O5, O6, O7;
    vec_t        oout;

    exp_t        sbq[$];
    vec_t        last_o;
    vec_t        cur_exp;
    int          edge_n = 0;
    int          n_vec  = 0;
    int          n_fail = 0;
    int          cm[8][8];

    always #5 aclk = ~aclk;

    assign oout = {O7, O6, O5, O4, O3, O2, O1, O0};

    dct_1d dut (
        .aclk(aclk), .areset(areset), .in_valid(in_valid),
        .I0(xin[0]), .I1(xin[1]), .I2(xin[2]), .I3(xin[3]),
        .I4(xin[4]), .I5(xin[5]), .I6(xin[6]), .I7(xin[7]),
        .out_valid(out_valid),
        .O0(O0), .O1(O1), .O2(O2), .O3(O3), .O4(O4), .O5(O5), .O6(O6), .O7(O7)
    );

    function automatic vec_t model(input vec_t x);
        vec_t   y;
        longint acc;
        longint r;
        for (int k = 0; k < 8; k++) begin
            acc = 0;
            for (int n = 0; n < 8; n++) begin
                acc += longint'($signed(x[n])) * longint'(cm[k][n]);
            end
            r = (acc + 64'sd8192) >>> 14;
`ifdef DCT_1D_SATURATE_EN
            if (r > 64'sd2147483647) r = 64'sd2147483647;
            if (r < -64'sd2147483648) r = -64'sd2147483648;
`endif
            y[k] = r[31:0];
        end
        return y;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s @edge %0d: observed %0d (0x%08h), expected %0d (0x%08h)",
                   tag, edge_n, $signed(obs), obs, $signed(expv), expv);
        end
    endtask

    // One clock: update the scoreboard from what the DUT sampled, then check its outputs.
    task automatic tick();
        exp_t e;
        @(posedge aclk);
        edge_n++;
        if (areset) begin
            sbq.delete();
            last_o = '0;
        end else if (in_valid) begin
            e.due = edge_n + 3;
            e.o   = cur_exp;
            sbq.push_back(e);
        end
        #1;
        if (sbq.size() > 0 && sbq[0].due == edge_n) begin
            chk("out_valid", {31'd0, out_valid}, 32'd1);
            for (int i = 0; i < 8; i++) chk($sformatf("O%0d", i), oout[i], sbq[0].o[i]);
            last_o = sbq[0].o;
            void'(sbq.pop_front());
        end else begin
            chk("out_valid_idle", {31'd0, out_valid}, 32'd0);
            for (int i = 0; i < 8; i++) chk($sformatf("hold_O%0d", i), oout[i], last_o[i]);
        end
    endtask

    task automatic drive(input logic v, input vec_t x, input vec_t e);
        in_valid = v;
        xin      = x;
        cur_exp  = e;
        tick();
    endtask

    task automatic idle(input int cycles);
        vec_t junk;
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < 8; i++) junk[i] = $urandom;
            drive(1'b0, junk, '0);
        end
    endtask

    vec_t dc_v, dc_e, imp_v, imp_e, neg_v, neg_e, sat_v, sat_e, rv;

    initial begin
        for (int k = 0; k < 8; k++) begin
            for (int n = 0; n < 8; n++) begin
                real a, v;
                a = (k == 0) ? $sqrt(1.0 / 8.0) : 0.5;
                v = 16384.0 * a * $cos((2.0 * n + 1.0) * k * 3.14159265358979 / 16.0);
                cm[k][n] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
            end
        end

        dc_v  = '0; dc_e  = '0; imp_v = '0; neg_v = '0; sat_v = '0; sat_e = '0;
        for (int i = 0; i < 8; i++) begin
            dc_v[i]  = 32'd100;
            sat_v[i] = 32'h7FFF_FFFF;
        end
        dc_e[0]  = 32'd283;
        imp_v[0] = 32'd16384;
        neg_v[0] = -32'sd16384;
        imp_e    = {32'd1598, 32'd3135, 32'd4551, 32'd5793, 32'd6811, 32'd7568, 32'd8035, 32'd5793};
        for (int i = 0; i < 8; i++) neg_e[i] = -imp_e[i];
`ifdef DCT_1D_SATURATE_EN
        sat_e[0] = 32'h7FFF_FFFF;
`else
        sat_e[0] = 32'd1779433469;
`endif
        last_o = '0;

        // Reset with a valid vector present: nothing may be accepted.
        areset = 1'b1;
        drive(1'b1, dc_v, dc_e);
        drive(1'b1, imp_v, imp_e);
        areset = 1'b0;

        drive(1'b1, dc_v, dc_e);
        idle(4);
        drive(1'b1, imp_v, imp_e);
        idle(4);
        drive(1'b1, neg_v, neg_e);
        idle(4);
        drive(1'b1, sat_v, sat_e);
        idle(4);

        // Back-to-back throughput.
        drive(1'b1, dc_v, dc_e);
        drive(1'b1, imp_v, imp_e);
        drive(1'b1, neg_v, neg_e);
        idle(4);

        // Random vectors, some back-to-back, some with gaps.
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 8; i++) rv[i] = (t < 6) ? $urandom : 32'($signed($urandom_range(0, 200000)) - 100000);
            drive(1'b1, rv, model(rv));
            if (t % 4 == 3) idle(2);
        end
        idle(4);

        // Reset one cycle after a valid vector: the vector is discarded.
        drive(1'b1, imp_v, imp_e);
        areset = 1'b1;
        idle(1);
        areset = 1'b0;
        idle(5);
        drive(1'b1, neg_v, neg_e);
        idle(5);

        chk("scoreboard_drained", sbq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
